linedraw_bres: RTL

- Parametrised successor to the lab line-draw engine. Rasterises one line from (stax,stay) to (endx,endy) inclusive, using integer Bresenham with independent X/Y widths.
- Emits one framebuffer write address per pixel and honours write backpressure.
- Adds abort, a done pulse and a pixel count.
- Sits between the command/sequencer logic and the framebuffer write port; video timing is unaffected.

---
 rtl/linedraw_pkg.sv | 18 +
 rtl/linedraw_bres_if.sv | 31 +++
 rtl/bres_step.sv | 40 ++++
 rtl/linedraw_bres.sv | 154 +++++++++++++++
 4 files changed

// File: rtl/linedraw_pkg.sv
// Shared types and defaults for the Bresenham line-draw engine.
package linedraw_pkg;

    // Default framebuffer geometry, shared with the framebuffer and address generator.
    localparam int XW_DEF = 8;
    localparam int YW_DEF = 8;

    typedef enum logic {
        IDLE = 1'b0,
        DRAW = 1'b1
    } state_t;

    // Delta width: wide enough for either axis.
    function automatic int max_w(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/linedraw_bres_if.sv
// Command / framebuffer-write bundle for the line-draw engine.
// master: command source + framebuffer side; slave: the engine.
interface linedraw_bres_if #(
    parameter int XW = linedraw_pkg::XW_DEF,
    parameter int YW = linedraw_pkg::YW_DEF
) ();
    localparam int DW = linedraw_pkg::max_w(XW, YW);

    logic            go;
    logic            abort;
    logic [XW-1:0]   stax;
    logic [YW-1:0]   stay;
    logic [XW-1:0]   endx;
    logic [YW-1:0]   endy;
    logic            busy;
    logic            wr;
    logic            wr_rdy;
    logic [XW+YW-1:0] addr;
    logic            done;
    logic [DW:0]     pix_cnt;

    modport master (
        output go, abort, stax, stay, endx, endy, wr_rdy,
        input  busy, wr, addr, done, pix_cnt
    );

    modport slave (
        input  go, abort, stax, stay, endx, endy, wr_rdy,
        output busy, wr, addr, done, pix_cnt
    );
endinterface

// File: rtl/bres_step.sv
// One Bresenham step: decides x/y advance from the pre-update error term
// and returns the next error and coordinates. Purely combinational.
module bres_step
    import linedraw_pkg::*;
#(
    parameter int XW = 8,
    parameter int YW = 8,
    parameter int DW = max_w(XW, YW)
) (
    input  logic signed [DW+1:0] err,
    input  logic        [DW:0]   dx,    // |dx|, always >= 0
    input  logic signed [DW+1:0] dy,    // -|dy|, always <= 0
    input  logic                 sx,    // 1: x steps downward
    input  logic                 sy,    // 1: y steps downward
    input  logic        [XW-1:0] x,
    input  logic        [YW-1:0] y,
    output logic signed [DW+1:0] err_n,
    output logic        [XW-1:0] x_n,
    output logic        [YW-1:0] y_n
);
    // One extra bit of headroom so 2*err and the two-term sum never wrap.
    logic signed [DW+2:0] e2, dxs, dys, acc;
    logic                 step_x, step_y;

    // Both tests use the error before this step's update; both may fire (diagonal).
    always_comb begin
        e2     = $signed({err, 1'b0});
        dxs    = $signed({2'b00, dx});
        dys    = $signed({dy[DW+1], dy});
        step_x = (e2 >= dys);
        step_y = (e2 <= dxs);
        acc    = $signed({err[DW+1], err})
               + (step_x ? dys : '0)
               + (step_y ? dxs : '0);
        err_n  = acc[DW+1:0];
        x_n    = step_x ? (sx ? x - XW'(1) : x + XW'(1)) : x;
        y_n    = step_y ? (sy ? y - YW'(1) : y + YW'(1)) : y;
    end

endmodule

// File: rtl/linedraw_bres.sv
// Bresenham line rasteriser: latches a line on go, emits one {y,x} write
// per pixel under wr/wr_rdy backpressure, then pulses done.
module linedraw_bres
    import linedraw_pkg::*;
#(
    parameter int XW = XW_DEF,
    parameter int YW = YW_DEF
) (
    input  logic            pclk,
    input  logic            rst,
    linedraw_bres_if.slave  bus
);
    localparam int DW = max_w(XW, YW);

    state_t               state_q, state_d;
    logic        [XW-1:0] x_q, x_d, ex_q, ex_d;
    logic        [YW-1:0] y_q, y_d, ey_q, ey_d;
    logic                 sx_q, sx_d, sy_q, sy_d;
    logic        [DW:0]   dx_q, dx_d;
    logic signed [DW+1:0] dy_q, dy_d;
    logic signed [DW+1:0] err_q, err_d;
    logic        [DW:0]   pix_cnt_q, pix_cnt_d;
    logic                 done_q, done_d;

    // Setup values derived from the command inputs (used only in the go cycle).
    logic        [XW-1:0] dxa;
    logic        [YW-1:0] dya;
    logic        [DW:0]   dx_c, dy_mag;
    logic signed [DW+1:0] dy_c, err_c;
    logic                 sx_c, sy_c;

    // Next-step values from the current latched state.
    logic signed [DW+1:0] err_n;
    logic        [XW-1:0] x_n;
    logic        [YW-1:0] y_n;
    logic                 at_end;

    bres_step #(.XW(XW), .YW(YW), .DW(DW)) u_step (
        .err   (err_q),
        .dx    (dx_q),
        .dy    (dy_q),
        .sx    (sx_q),
        .sy    (sy_q),
        .x     (x_q),
        .y     (y_q),
        .err_n (err_n),
        .x_n   (x_n),
        .y_n   (y_n)
    );

    // Command decode: step directions, absolute deltas and initial error.
    always_comb begin
        sx_c   = (bus.endx < bus.stax);
        sy_c   = (bus.endy < bus.stay);
        dxa    = sx_c ? (bus.stax - bus.endx) : (bus.endx - bus.stax);
        dya    = sy_c ? (bus.stay - bus.endy) : (bus.endy - bus.stay);
        dx_c   = '0;
        dx_c[XW-1:0] = dxa;
        dy_mag = '0;
        dy_mag[YW-1:0] = dya;
        dy_c   = -$signed({1'b0, dy_mag});
        err_c  = $signed({1'b0, dx_c}) + dy_c;
    end

    assign at_end = (x_q == ex_q) && (y_q == ey_q);

    // FSM next-state and datapath updates; abort beats go and beats the endpoint.
    always_comb begin
        state_d   = state_q;
        x_d       = x_q;
        y_d       = y_q;
        ex_d      = ex_q;
        ey_d      = ey_q;
        sx_d      = sx_q;
        sy_d      = sy_q;
        dx_d      = dx_q;
        dy_d      = dy_q;
        err_d     = err_q;
        pix_cnt_d = pix_cnt_q;
        done_d    = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.go && !bus.abort) begin
                    state_d   = DRAW;
                    x_d       = bus.stax;
                    y_d       = bus.stay;
                    ex_d      = bus.endx;
                    ey_d      = bus.endy;
                    sx_d      = sx_c;
                    sy_d      = sy_c;
                    dx_d      = dx_c;
                    dy_d      = dy_c;
                    err_d     = err_c;
                    pix_cnt_d = '0;
                end
            end
            DRAW: begin
                if (bus.wr_rdy)
                    pix_cnt_d = pix_cnt_q + (DW+1)'(1);
                if (bus.abort) begin
                    state_d = IDLE;
                end else if (bus.wr_rdy) begin
                    if (at_end) begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end else begin
                        x_d   = x_n;
                        y_d   = y_n;
                        err_d = err_n;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge pclk) begin
        if (rst) begin
            state_q   <= IDLE;
            x_q       <= '0;
            y_q       <= '0;
            ex_q      <= '0;
            ey_q      <= '0;
            sx_q      <= 1'b0;
            sy_q      <= 1'b0;
            dx_q      <= '0;
            dy_q      <= '0;
            err_q     <= '0;
            pix_cnt_q <= '0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            x_q       <= x_d;
            y_q       <= y_d;
            ex_q      <= ex_d;
            ey_q      <= ey_d;
            sx_q      <= sx_d;
            sy_q      <= sy_d;
            dx_q      <= dx_d;
            dy_q      <= dy_d;
            err_q     <= err_d;
            pix_cnt_q <= pix_cnt_d;
            done_q    <= done_d;
        end
    end

    assign bus.busy    = (state_q == DRAW);
    assign bus.wr      = (state_q == DRAW);
    assign bus.addr    = {y_q, x_q};
    assign bus.done    = done_q;
    assign bus.pix_cnt = pix_cnt_q;

endmodule
